// File: rtl/bus_pkg.sv
// bus_pkg: shared APB arbiter types and slave-index field bounds
package bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;
  localparam int SLV_IDX_MSB = 15;
  localparam int SLV_IDX_LSB = 12;
  localparam int MAX_SLAVE = 16;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter
// Ports: clk, reset (async active-low), req[1:0] requests, grant_en commits a grant,
//        gnt_valid any request present, gnt_idx winning requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  logic last_gnt;
  assign gnt_valid = |req;
  // on a tie the master not granted last time wins
  assign gnt_idx = &req ? ~last_gnt : req[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_gnt <= 1'b1;
    else if (grant_en && gnt_valid) last_gnt <= gnt_idx;
endmodule

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: two-master round-robin APB3 bus master with slave decode
// Ports: clk, reset (async active-low); per master mX_req/mX_we/mX_addr/mX_wdata in,
//        mX_rdata/mX_ready/mX_err out; APB PADDR/PWRITE/PWDATA/PENABLE/PSEL out,
//        PRDATA/PREADY/PSLVERR in. Define APB_TIMEOUT_EN to end a stalled ACCESS
//        with an error after TIMEOUT cycles.
module apb_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NSLAVE  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m0_rdata,
  output logic [31:0]       m1_rdata,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic              m0_err,
  output logic              m1_err,
  output logic [31:0]       PADDR,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  output logic              PENABLE,
  output logic [NSLAVE-1:0] PSEL,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  if (NSLAVE < 1 || NSLAVE > MAX_SLAVE || TIMEOUT < 1) begin : g_bad_param
    $error("apb_bus_arbiter: parameter out of range");
  end
  apb_state_e state_q, state_d;
  logic gnt_valid, gnt_idx, grant, dec_ok, gnt_q, err_q, tmo, sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [SLV_IDX_MSB-SLV_IDX_LSB:0] slv;
  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({m1_req, m0_req}),
    .grant_en (grant),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );
  assign grant     = state_q == IDLE && gnt_valid;
  assign sel_we    = gnt_idx ? m1_we : m0_we;
  assign sel_addr  = gnt_idx ? m1_addr : m0_addr;
  assign sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
  assign dec_ok    = 32'(sel_addr[SLV_IDX_MSB:SLV_IDX_LSB]) < NSLAVE;
  assign slv       = PADDR[SLV_IDX_MSB:SLV_IDX_LSB];
`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  // held at zero outside ACCESS, so it starts cleared on every ACCESS entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (state_q != ACCESS) cnt <= '0;
    else if (!PREADY) cnt <= cnt + 1'b1;
  assign tmo = state_q == ACCESS && !PREADY && cnt == TW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d  = state_q == IDLE   ? (gnt_valid ? (dec_ok ? SETUP : DONE) : IDLE)
             : state_q == SETUP  ? ACCESS
             : state_q == ACCESS ? (PREADY || tmo ? DONE : ACCESS)
             : IDLE;
    PENABLE  = state_q == ACCESS;
    PSEL     = (state_q == SETUP || state_q == ACCESS) ? NSLAVE'(1) << slv : '0;
    m0_ready = state_q == DONE && !gnt_q;
    m1_ready = state_q == DONE && gnt_q;
    m0_err   = m0_ready && err_q;
    m1_err   = m1_ready && err_q;
  end
  // APB address/data registers only move on a decodable grant so they hold
  // their last values through IDLE, DONE and decode-error completions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (grant) begin
      gnt_q <= gnt_idx;
      err_q <= !dec_ok;
      if (dec_ok) begin
        PADDR  <= sel_addr;
        PWRITE <= sel_we;
        PWDATA <= sel_wdata;
      end
    end else if (state_q == ACCESS && PREADY) begin
      err_q <= PSLVERR;
      if (!PWRITE && !gnt_q) m0_rdata <= PRDATA;
      if (!PWRITE && gnt_q) m1_rdata <= PRDATA;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end
endmodule

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Two-requester APB3 bus master for the multicycle RISC-V core. It arbitrates the CPU data port (master 0) and the DMA engine (master 1) onto one shared APB fabric, then sequences the SETUP/ACCESS phases, including wait states. It also decodes the slave select and returns a registered completion pulse. The CPU control unit holds its memory state until `m0_ready` pulses.

## Interface
- `NSLAVE`, 4: number of APB slaves, 1..16; slave index is `PADDR[15:12]`.
- `TIMEOUT`, 16: ACCESS-phase cycle limit; only used with `APB_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `m0_req`, `m1_req` in 1: transfer request; held until that master's `ready`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read; stable while `req` is high.
- `m0_addr`, `m1_addr` in 32: byte address; stable while `req` is high.
- `m0_wdata`, `m1_wdata` in 32: write data; stable while `req` is high.
- `m0_rdata`, `m1_rdata` out 32: read data, valid in the `ready` cycle.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: error flag, valid with `ready`.
- `PADDR` out 32, `PWRITE` out 1, `PWDATA` out 32, `PENABLE` out 1, `PSEL` out NSLAVE: APB master outputs.
- `PRDATA` in 32, `PREADY` in 1, `PSLVERR` in 1: APB returns, already muxed by the fabric.

## Operation
- FSM states are IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - If any `req` is high, the arbiter picks a winner and latches its `we`, `addr` and `wdata`, plus the grant index `gnt`.
  - If `addr[15:12] < NSLAVE`, go to SETUP.
  - Otherwise set the error flag and go to DONE without any APB activity.
- **Arbitration**
  - A single requester wins.
  - When both request, the master not granted last time wins.
  - `last_gnt` updates on every grant; its reset value is 1, so master 0 wins the first tie.
- **SETUP**
  - `PSEL[idx]=1`, `PENABLE=0`, `PADDR`/`PWRITE`/`PWDATA` driven from the latches.
  - Always goes to ACCESS after one cycle.
- **ACCESS**
  - `PSEL[idx]=1`, `PENABLE=1`.
  - If `PREADY=1`: capture `PRDATA` (reads only) and `PSLVERR` into the error flag, then go to DONE.
  - If `PREADY=0`: stay in ACCESS.
- **DONE**
  - `mX_ready=1` and `mX_err` driven for the granted master only; `mX_rdata` holds the captured data.
  - Always goes to IDLE.
- A request newly arriving in DONE is not evaluated until IDLE.
- **Outputs in IDLE and DONE:** `PSEL=0`, `PENABLE=0`; `PADDR`, `PWRITE` and `PWDATA` hold their last values.
- **Reset values:** state IDLE; `PSEL=0`; `PENABLE=0`; `PADDR=0`; `PWRITE=0`; `PWDATA=0`; both `rdata=0`; all `ready=0`; all `err=0`; `last_gnt=1`.
- **Write transfers:** `rdata` keeps its previous value.
- **Reset mid-transfer:** the FSM aborts immediately to IDLE with all outputs at reset values. No `ready` is issued, and requesters re-issue after reset.
- **Protocol violation:** a master dropping `req` before its `ready` is not supported; the transfer completes anyway.

## Timing
- Zero-wait-state transfer latency:
  - `req` sampled at edge 0 moves the FSM to SETUP.
  - Edge 1 moves it to ACCESS.
  - `PREADY=1` at edge 2 moves it to DONE.
  - `ready` is high between edges 2 and 3.
- Total latency is 3 cycles from the `req` sampling edge to `ready`. Each `PREADY=0` cycle adds one.
- Decode-error latency is 1 cycle (IDLE → DONE).
- Back-to-back throughput: a new grant at the earliest 4 cycles after the previous grant, so a waiting master is served after at most one transfer of the other.
- `ready` and `err` are registered (state-decoded), with no combinational path from `PREADY`.

## Configuration
- **`APB_TIMEOUT_EN` defined:**
  - A counter clears on entering ACCESS and increments each ACCESS cycle while `PREADY=0`.
  - When it reaches `TIMEOUT`, the FSM goes to DONE with `err=1` and `rdata` unchanged.
  - `PSEL` and `PENABLE` drop in DONE.
- **`APB_TIMEOUT_EN` undefined:** no counter exists; ACCESS waits indefinitely for `PREADY`.

## Structure
- **Package `bus_pkg`:**
  - `apb_state_e` (IDLE, SETUP, ACCESS, DONE).
  - Slave index field bounds: `SLV_IDX_MSB=15`, `SLV_IDX_LSB=12`.
  - `MAX_SLAVE=16`.
- **Sub-module `rr_arbiter2`:** two-way round-robin arbiter.
  - Ports: `clk`, `reset`, `req[1:0]`, `grant_en`, `gnt_valid`, `gnt_idx`.
  - Owns `last_gnt`; updates only when `grant_en` is high.

## Test plan
- m0 read at `0x0000_1004`, `PREADY=1` immediately, `PRDATA=0xDEADBEEF`:
  - `PSEL=4'b0010` in SETUP and ACCESS.
  - `m0_ready` pulses 3 cycles after `req` with `m0_rdata=0xDEADBEEF`, `m0_err=0`.
- m1 write `0x12345678` to `0x0000_3000` with `PREADY` low for 2 cycles:
  - `PWRITE=1`, `PSEL=4'b1000`, ACCESS lasts 3 cycles.
  - `m1_ready` pulses 5 cycles after `req`.
- Both `req` high from reset, then both held:
  - Grants alternate m0, m1, m0.
  - Each `ready` pulses exactly once per transfer.
- m0 request to `0x0000_5000` with `NSLAVE=4`:
  - No `PSEL` activity.
  - `m0_ready=1` and `m0_err=1` one cycle after `req`.
- `PSLVERR=1` with `PREADY=1` on an m1 read → `m1_err=1` in the `ready` cycle.
- `reset` low during ACCESS → `PSEL=0` and `PENABLE=0` immediately, no `ready` pulse.
- With `APB_TIMEOUT_EN` and `PREADY` held low → `err=1` with `ready` after 16 ACCESS cycles.
